// File: rtl/nibble_assembler_pkg.sv
// Shared definitions for the nibble assembler: default geometry, FSM encoding
// and the slot-to-bit-offset helper.
package nibble_assembler_pkg;

  localparam int DEF_NUM_NIB = 8;
  localparam int DEF_NIB_W   = 4;
  localparam int DEF_POS_W   = 3;

  typedef enum logic {
    FILL   = 1'b0,
    SEALED = 1'b1
  } state_e;

  function automatic int unsigned slotOffset(input int unsigned pos, input int unsigned nibW);
    return pos * nibW;
  endfunction

endpackage

// File: rtl/nibble_assembler_out_reg.sv
// Valid/ready holding register for a finished word and its slot mask.
// slotFree_o says a new word may be loaded at the coming edge.
module nibble_out_reg
  #(parameter int WORD_W  = 32,
    parameter int NUM_NIB = 8)
  (input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic [WORD_W-1:0]  word_i,
   input  logic [NUM_NIB-1:0] mask_i,
   input  logic               ready_i,
   output logic [WORD_W-1:0]  word_o,
   output logic [NUM_NIB-1:0] mask_o,
   output logic               valid_o,
   output logic               slotFree_o);

  logic [WORD_W-1:0]  word_q;
  logic [NUM_NIB-1:0] mask_q;
  logic               valid_q;

  assign slotFree_o = !valid_q || ready_i;

  // Data is only replaced on a load, so a popped word stays visible on word_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      mask_q  <= mask_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign word_o  = word_q;
  assign mask_o  = mask_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/nibble_assembler.sv
// Packs slot-tagged nibbles back into a word; accumulation keeps going while a
// finished word waits in the output register.
module nibble_assembler
  import nibble_assembler_pkg::*;
  #(parameter int NUM_NIB = DEF_NUM_NIB,
    parameter int NIB_W   = DEF_NIB_W,
    parameter int POS_W   = DEF_POS_W)
  (input  logic                     CLK,
   input  logic                     RESET_L,
   input  logic [NIB_W-1:0]         NIBBLE_IN,
   input  logic [POS_W-1:0]         NIBBLE_POS,
   input  logic                     NIBBLE_VALID,
   output logic                     NIBBLE_READY,
   input  logic                     FLUSH,
   output logic [NUM_NIB*NIB_W-1:0] WORD_OUT,
   output logic [NUM_NIB-1:0]       WORD_MASK,
   output logic                     WORD_VALID,
   input  logic                     WORD_READY,
   output logic                     DUP_ERR);

  localparam int WORD_W = NUM_NIB * NIB_W;

  state_e             state_q;
  logic [WORD_W-1:0]  accum_q;
  logic [NUM_NIB-1:0] mask_q;
  logic               ready_q;
  logic               dupErr_q;

  logic [WORD_W-1:0]  accum_d;
  logic [NUM_NIB-1:0] mask_d;
  logic               accept;
  logic               sealReq;
  logic               slotFree;
  logic               loadWord;

  assign accept = NIBBLE_VALID && ready_q;

  // accum_d/mask_d already include a nibble accepted this cycle, so a word can seal on its last nibble.
  always_comb begin
    accum_d = accum_q;
    mask_d  = mask_q;
    if (accept) begin
      accum_d[slotOffset(int'(NIBBLE_POS), NIB_W) +: NIB_W] = NIBBLE_IN;
      mask_d[NIBBLE_POS] = 1'b1;
    end
  end

  always_comb begin
    sealReq = 1'b0;
    if (state_q == SEALED) begin
      sealReq = 1'b1;
    end else begin
      sealReq = (&mask_d) || (FLUSH && (|mask_d));
    end
  end

  assign loadWord = sealReq && slotFree;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q  <= FILL;
      accum_q  <= '0;
      mask_q   <= '0;
      ready_q  <= 1'b0;
      dupErr_q <= 1'b0;
    end else begin
      dupErr_q <= accept && mask_q[NIBBLE_POS];
      case (state_q)
        FILL: begin
          if (loadWord) begin
            accum_q <= '0;
            mask_q  <= '0;
            ready_q <= 1'b1;
          end else if (sealReq) begin
            state_q <= SEALED;
            accum_q <= accum_d;
            mask_q  <= mask_d;
            ready_q <= 1'b0;
          end else begin
            accum_q <= accum_d;
            mask_q  <= mask_d;
            ready_q <= 1'b1;
          end
        end
        SEALED: begin
          if (loadWord) begin
            state_q <= FILL;
            accum_q <= '0;
            mask_q  <= '0;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  nibble_out_reg #(.WORD_W(WORD_W), .NUM_NIB(NUM_NIB)) outReg (
    .clk_i      (CLK),
    .rst_ni     (RESET_L),
    .load_i     (loadWord),
    .word_i     (accum_d),
    .mask_i     (mask_d),
    .ready_i    (WORD_READY),
    .word_o     (WORD_OUT),
    .mask_o     (WORD_MASK),
    .valid_o    (WORD_VALID),
    .slotFree_o (slotFree)
  );

  assign NIBBLE_READY = ready_q;
  assign DUP_ERR      = dupErr_q;

endmodule

// File: tb/tb_nibble_assembler.sv
// Directed bench for nibble_assembler: each task drives one scenario and checks
// outputs #1 after the rising edge against hand-computed values.
module tb_nibble_assembler;

  logic        CLK;
  logic        RESET_L;
  logic [3:0]  NIBBLE_IN;
  logic [2:0]  NIBBLE_POS;
  logic        NIBBLE_VALID;
  logic        NIBBLE_READY;
  logic        FLUSH;
  logic [31:0] WORD_OUT;
  logic [7:0]  WORD_MASK;
  logic        WORD_VALID;
  logic        WORD_READY;
  logic        DUP_ERR;

  int vectors = 0;
  int errors  = 0;

  nibble_assembler dut (
    .CLK          (CLK),
    .RESET_L      (RESET_L),
    .NIBBLE_IN    (NIBBLE_IN),
    .NIBBLE_POS   (NIBBLE_POS),
    .NIBBLE_VALID (NIBBLE_VALID),
    .NIBBLE_READY (NIBBLE_READY),
    .FLUSH        (FLUSH),
    .WORD_OUT     (WORD_OUT),
    .WORD_MASK    (WORD_MASK),
    .WORD_VALID   (WORD_VALID),
    .WORD_READY   (WORD_READY),
    .DUP_ERR      (DUP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sendNib(input int pos, input int val);
    NIBBLE_VALID = 1'b1;
    NIBBLE_POS   = 3'(pos);
    NIBBLE_IN    = 4'(val);
    step();
    NIBBLE_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET_L = 1'b0;
    #2;
    vectors++;
    if (WORD_OUT !== 32'h0) begin errors++; $display("[TB] FAIL reset_word got %h want %h", WORD_OUT, 32'h0); end
    vectors++;
    if (WORD_MASK !== 8'h0) begin errors++; $display("[TB] FAIL reset_mask got %h want %h", WORD_MASK, 8'h0); end
    vectors++;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", WORD_VALID); end
    vectors++;
    if (DUP_ERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_dup got %b want 0", DUP_ERR); end
    step();
    RESET_L = 1'b1;
    step();
    vectors++;
    if (NIBBLE_READY !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", NIBBLE_READY); end
  endtask

  task automatic test_full_word();
    WORD_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sendNib(k, k + 1);
      if (k == 6) begin
        vectors++;
        if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL full_early got %b want 0", WORD_VALID); end
      end
    end
    vectors++;
    if (WORD_VALID !== 1'b1) begin errors++; $display("[TB] FAIL full_valid got %b want 1", WORD_VALID); end
    vectors++;
    if (WORD_OUT !== 32'h87654321) begin errors++; $display("[TB] FAIL full_word got %h want %h", WORD_OUT, 32'h87654321); end
    vectors++;
    if (WORD_MASK !== 8'hFF) begin errors++; $display("[TB] FAIL full_mask got %h want %h", WORD_MASK, 8'hFF); end
    step();
    vectors++;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL full_pop got %b want 0", WORD_VALID); end
    vectors++;
    if (WORD_OUT !== 32'h87654321) begin errors++; $display("[TB] FAIL full_keep got %h want %h", WORD_OUT, 32'h87654321); end
  endtask

  task automatic test_flush();
    sendNib(2, 4'hA);
    sendNib(5, 4'hC);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    vectors++;
    if (WORD_VALID !== 1'b1) begin errors++; $display("[TB] FAIL flush_valid got %b want 1", WORD_VALID); end
    vectors++;
    if (WORD_OUT !== 32'h00C00A00) begin errors++; $display("[TB] FAIL flush_word got %h want %h", WORD_OUT, 32'h00C00A00); end
    vectors++;
    if (WORD_MASK !== 8'h24) begin errors++; $display("[TB] FAIL flush_mask got %h want %h", WORD_MASK, 8'h24); end
    step();
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    vectors++;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got %b want 0", WORD_VALID); end
  endtask

  task automatic test_dup();
    sendNib(3, 4'h5);
    vectors++;
    if (DUP_ERR !== 1'b0) begin errors++; $display("[TB] FAIL dup_first got %b want 0", DUP_ERR); end
    sendNib(3, 4'h9);
    vectors++;
    if (DUP_ERR !== 1'b1) begin errors++; $display("[TB] FAIL dup_pulse got %b want 1", DUP_ERR); end
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    vectors++;
    if (DUP_ERR !== 1'b0) begin errors++; $display("[TB] FAIL dup_clear got %b want 0", DUP_ERR); end
    vectors++;
    if (WORD_OUT !== 32'h00009000) begin errors++; $display("[TB] FAIL dup_word got %h want %h", WORD_OUT, 32'h00009000); end
    vectors++;
    if (WORD_MASK !== 8'h08) begin errors++; $display("[TB] FAIL dup_mask got %h want %h", WORD_MASK, 8'h08); end
    step();
  endtask

  task automatic test_backpressure();
    WORD_READY = 1'b0;
    for (int k = 0; k < 8; k++) sendNib(k, k + 8);
    vectors++;
    if (WORD_OUT !== 32'hFEDCBA98) begin errors++; $display("[TB] FAIL bp_first got %h want %h", WORD_OUT, 32'hFEDCBA98); end
    for (int k = 0; k < 8; k++) begin
      sendNib(k, 7 - k);
      if (k == 3) begin
        vectors++;
        if (WORD_OUT !== 32'hFEDCBA98) begin errors++; $display("[TB] FAIL bp_stable got %h want %h", WORD_OUT, 32'hFEDCBA98); end
      end
    end
    step();
    vectors++;
    if (NIBBLE_READY !== 1'b0) begin errors++; $display("[TB] FAIL bp_sealed got %b want 0", NIBBLE_READY); end
    vectors++;
    if (WORD_OUT !== 32'hFEDCBA98 || WORD_VALID !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold got %h/%b want %h/1", WORD_OUT, WORD_VALID, 32'hFEDCBA98); end
    WORD_READY = 1'b1;
    step();
    vectors++;
    if (WORD_OUT !== 32'h01234567 || WORD_VALID !== 1'b1) begin errors++; $display("[TB] FAIL bp_second got %h/%b want %h/1", WORD_OUT, WORD_VALID, 32'h01234567); end
    vectors++;
    if (NIBBLE_READY !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume got %b want 1", NIBBLE_READY); end
    step();
    vectors++;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b want 0", WORD_VALID); end
  endtask

  task automatic test_back_to_back();
    logic expValid;
    WORD_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (NIBBLE_READY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d got %b want 1", i, NIBBLE_READY); end
      NIBBLE_VALID = 1'b1;
      NIBBLE_POS   = 3'(i % 8);
      NIBBLE_IN    = (i < 8) ? 4'(i) : 4'((i - 8) ^ 15);
      step();
      expValid = (i == 7) || (i == 15);
      vectors++;
      if (WORD_VALID !== expValid) begin errors++; $display("[TB] FAIL b2b_valid%0d got %b want %b", i, WORD_VALID, expValid); end
      if (i == 7) begin
        vectors++;
        if (WORD_OUT !== 32'h76543210) begin errors++; $display("[TB] FAIL b2b_word0 got %h want %h", WORD_OUT, 32'h76543210); end
      end
      if (i == 15) begin
        vectors++;
        if (WORD_OUT !== 32'h89ABCDEF) begin errors++; $display("[TB] FAIL b2b_word1 got %h want %h", WORD_OUT, 32'h89ABCDEF); end
      end
    end
    NIBBLE_VALID = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    WORD_READY = 1'b0;
    for (int k = 0; k < 8; k++) sendNib(k, k + 1);
    for (int k = 0; k < 4; k++) sendNib(k, 4'h3);
    vectors++;
    if (WORD_VALID !== 1'b1 || NIBBLE_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre got %b/%b want 1/1", WORD_VALID, NIBBLE_READY); end
    RESET_L = 1'b0;
    #1;
    vectors++;
    if (WORD_OUT !== 32'h0 || WORD_MASK !== 8'h0) begin errors++; $display("[TB] FAIL rst_data got %h/%h want 0/0", WORD_OUT, WORD_MASK); end
    vectors++;
    if (WORD_VALID !== 1'b0 || NIBBLE_READY !== 1'b0 || DUP_ERR !== 1'b0) begin errors++; $display("[TB] FAIL rst_ctrl got %b%b%b want 000", WORD_VALID, NIBBLE_READY, DUP_ERR); end
    #1;
    RESET_L = 1'b1;
    step();
    WORD_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sendNib(k, 2 * k);
      vectors++;
      if (DUP_ERR !== 1'b0) begin errors++; $display("[TB] FAIL rst_dup%0d got %b want 0", k, DUP_ERR); end
    end
    vectors++;
    if (WORD_OUT !== 32'hECA86420 || WORD_MASK !== 8'hFF) begin errors++; $display("[TB] FAIL rst_fresh got %h/%h want %h/ff", WORD_OUT, WORD_MASK, 32'hECA86420); end
  endtask

  initial begin
    NIBBLE_IN    = '0;
    NIBBLE_POS   = '0;
    NIBBLE_VALID = 1'b0;
    FLUSH        = 1'b0;
    WORD_READY   = 1'b0;
    test_reset();
    test_full_word();
    test_flush();
    test_dup();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
